// File: rtl/vadd_float_chunk_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vadd_float_pkg
// Purpose  : Shared types and helpers for the vadd_float chunk scheduler.
//            Holds the scheduler state encoding, the default datapath beat
//            width in bytes and an unsigned min() helper used to size chunks.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vadd_float_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    ADVANCE = 3'd3,
    DONE    = 3'd4
  } sched_state_t;

  // Bytes per beat for the default 32-bit datapath.
  localparam int LP_DW_BYTES = 4;

  function automatic logic [63:0] min_u64(input logic [63:0] x, input logic [63:0] y);
    return (x < y) ? x : y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vadd_float_chunk_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : vadd_float_chunk_scheduler_if
// Purpose  : Chunk command / completion bundle between the scheduler and the
//            two AXI read masters plus the AXI write master.
// Signals  : chunk_start        - one-cycle chunk start pulse
//            chunk_{a,b,c}_offset - current chunk base addresses
//            chunk_length       - current chunk size in bytes
//            rd_a_done, rd_b_done, wr_done - per-master completion pulses
// Modports : master (scheduler side), slave (datapath side)
// Revision : 1.0 - initial release
// ============================================================================
interface vadd_float_chunk_scheduler_if #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32
);
  import vadd_float_pkg::*;

  logic                         chunk_start;
  logic [C_ADDR_WIDTH-1:0]      chunk_a_offset;
  logic [C_ADDR_WIDTH-1:0]      chunk_b_offset;
  logic [C_ADDR_WIDTH-1:0]      chunk_c_offset;
  logic [C_XFER_SIZE_WIDTH-1:0] chunk_length;
  logic                         rd_a_done;
  logic                         rd_b_done;
  logic                         wr_done;

  modport master (
    output chunk_start, chunk_a_offset, chunk_b_offset, chunk_c_offset, chunk_length,
    input  rd_a_done, rd_b_done, wr_done
  );

  modport slave (
    input  chunk_start, chunk_a_offset, chunk_b_offset, chunk_c_offset, chunk_length,
    output rd_a_done, rd_b_done, wr_done
  );

endinterface
`default_nettype wire

// File: rtl/vadd_float_chunk_scheduler_done_join.sv
`default_nettype none
// ============================================================================
// Module   : vadd_float_done_join
// Purpose  : Joins the three master done pulses of one chunk. Each pulse sets
//            a sticky flag while enabled; all_done_o also counts pulses of the
//            current cycle so the join costs no extra cycle.
// Ports    : ap_clk, areset     - clock, synchronous active-high reset
//            clr_i              - clear all sticky flags
//            en_i               - accept done pulses (ignored otherwise)
//            rd_a_done_i, rd_b_done_i, wr_done_i - master done pulses
//            all_done_o         - all three masters have finished
// Revision : 1.0 - initial release
// ============================================================================
module vadd_float_done_join
  import vadd_float_pkg::*;
(
  input  wire  ap_clk,
  input  wire  areset,
  input  wire  clr_i,
  input  wire  en_i,
  input  wire  rd_a_done_i,
  input  wire  rd_b_done_i,
  input  wire  wr_done_i,
  output logic all_done_o
);

  logic [2:0] flags_q;
  logic [2:0] w_hit;

  assign w_hit      = {wr_done_i, rd_b_done_i, rd_a_done_i} & {3{en_i}};
  assign all_done_o = &(flags_q | w_hit);

  always_ff @(posedge ap_clk) begin
    if (areset || clr_i) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_q | w_hit;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vadd_float_chunk_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vadd_float_chunk_scheduler
// Purpose  : Splits one vadd_float kernel invocation into chunks of at most
//            C_CHUNK_BYTES, issues one chunk_start per chunk and joins the
//            three master done pulses. Owns ap_start/ap_idle/ap_done/ap_ready.
// Ports    : ap_clk, areset   - clock, synchronous active-high reset
//            ap_start         - start level (rising edge used)
//            ap_idle/ap_done/ap_ready - kernel control handshake
//            xfer_size, a, b, c - job size in bytes and base addresses
//            chunk_count      - chunks completed in the current job
//            timeout_err      - sticky watchdog error
//            chunk_if         - chunk command / done bundle (master side)
// Options  : VADD_FLOAT_CHUNK_TIMEOUT_EN - enables the WAIT watchdog
// Revision : 1.0 - initial release
// ============================================================================
module vadd_float_chunk_scheduler
  import vadd_float_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_DATA_WIDTH      = LP_DW_BYTES * 8,
  parameter int C_CHUNK_BYTES     = 65536,
  parameter int C_TIMEOUT_CYCLES  = 1048576
)(
  input  wire                          ap_clk,
  input  wire                          areset,
  input  wire                          ap_start,
  output logic                         ap_idle,
  output logic                         ap_done,
  output logic                         ap_ready,
  input  wire  [C_XFER_SIZE_WIDTH-1:0] xfer_size,
  input  wire  [C_ADDR_WIDTH-1:0]      a,
  input  wire  [C_ADDR_WIDTH-1:0]      b,
  input  wire  [C_ADDR_WIDTH-1:0]      c,
  output logic [C_XFER_SIZE_WIDTH-1:0] chunk_count,
  output logic                         timeout_err,
  vadd_float_chunk_scheduler_if.master chunk_if
);

  localparam int LP_BEAT_BYTES = C_DATA_WIDTH / 8;
  // Drops the partial trailing beat from the job size.
  localparam logic [C_XFER_SIZE_WIDTH-1:0] LP_SIZE_MASK =
    ~C_XFER_SIZE_WIDTH'(LP_BEAT_BYTES - 1);

  sched_state_t state_q, state_d;

  logic                         ap_start_q;
  logic                         ap_idle_q;
  logic [C_ADDR_WIDTH-1:0]      a_off_q, b_off_q, c_off_q;
  logic [C_XFER_SIZE_WIDTH-1:0] remaining_q;
  logic [C_XFER_SIZE_WIDTH-1:0] chunk_count_q;

  logic                         w_start_pulse;
  logic [C_XFER_SIZE_WIDTH-1:0] w_size_aligned;
  logic [C_XFER_SIZE_WIDTH-1:0] w_len;
  logic                         w_all_done;
  logic                         w_timeout;
  logic                         w_chunk_start;
  logic                         w_done_pulse;
  logic                         w_join_clr;
  logic                         w_join_en;

  assign w_start_pulse  = ap_start & ~ap_start_q;
  assign w_size_aligned = xfer_size & LP_SIZE_MASK;
  // Length depends only on remaining_q, so it is stable from ISSUE to ADVANCE.
  assign w_len = C_XFER_SIZE_WIDTH'(min_u64(64'(remaining_q), 64'(C_CHUNK_BYTES)));

  vadd_float_done_join u_join (
    .ap_clk      (ap_clk),
    .areset      (areset),
    .clr_i       (w_join_clr),
    .en_i        (w_join_en),
    .rd_a_done_i (chunk_if.rd_a_done),
    .rd_b_done_i (chunk_if.rd_b_done),
    .wr_done_i   (chunk_if.wr_done),
    .all_done_o  (w_all_done)
  );

`ifdef VADD_FLOAT_CHUNK_TIMEOUT_EN
  localparam int LP_WD_W = $clog2(C_TIMEOUT_CYCLES + 1);

  logic [LP_WD_W-1:0] wd_q;
  logic               timeout_err_q;

  // wd_q holds the number of WAIT cycles already elapsed for this chunk.
  assign w_timeout = (state_q == WAIT) && !w_all_done &&
                     (wd_q == LP_WD_W'(C_TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        wd_q <= '0;
      end else if (state_q == WAIT) begin
        wd_q <= wd_q + 1'b1;
      end
      if ((state_q == IDLE) && w_start_pulse) begin
        timeout_err_q <= 1'b0;
      end else if (w_timeout) begin
        timeout_err_q <= 1'b1;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = |32'(C_TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  // State register
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (w_start_pulse) begin
          state_d = (w_size_aligned == '0) ? DONE : ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (w_all_done) begin
          state_d = ADVANCE;
        end else if (w_timeout) begin
          state_d = DONE;
        end
      end
      ADVANCE: state_d = (remaining_q == w_len) ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_chunk_start = (state_q == ISSUE);
    w_join_clr    = (state_q == ISSUE);
    w_join_en     = (state_q == WAIT);
    w_done_pulse  = (state_q == DONE);
  end

  // Job / chunk bookkeeping
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ap_start_q    <= 1'b0;
      ap_idle_q     <= 1'b1;
      a_off_q       <= '0;
      b_off_q       <= '0;
      c_off_q       <= '0;
      remaining_q   <= '0;
      chunk_count_q <= '0;
    end else begin
      ap_start_q <= ap_start;
      unique case (state_q)
        IDLE: begin
          if (w_start_pulse) begin
            a_off_q       <= a;
            b_off_q       <= b;
            c_off_q       <= c;
            remaining_q   <= w_size_aligned;
            chunk_count_q <= '0;
            ap_idle_q     <= 1'b0;
          end
        end
        ADVANCE: begin
          a_off_q       <= a_off_q + C_ADDR_WIDTH'(w_len);
          b_off_q       <= b_off_q + C_ADDR_WIDTH'(w_len);
          c_off_q       <= c_off_q + C_ADDR_WIDTH'(w_len);
          remaining_q   <= remaining_q - w_len;
          chunk_count_q <= chunk_count_q + 1'b1;
        end
        DONE:    ap_idle_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign ap_idle                 = ap_idle_q;
  assign ap_done                 = w_done_pulse;
  assign ap_ready                = w_done_pulse;
  assign chunk_count             = chunk_count_q;
  assign chunk_if.chunk_start    = w_chunk_start;
  assign chunk_if.chunk_a_offset = a_off_q;
  assign chunk_if.chunk_b_offset = b_off_q;
  assign chunk_if.chunk_c_offset = c_off_q;
  assign chunk_if.chunk_length   = w_len;

endmodule
`default_nettype wire
